// File: rtl/cond_logic_unit_if.sv
// rtl/cond_logic_unit_if.sv - instruction/flag bundle between decoder/ALU and the condition unit
// The master drives an instruction and its ALU flags; the slave returns gated strobes and flags.
interface cond_logic_unit_if #(
  parameter int CNT_W = 16
) ();
  logic             valid;
  logic [3:0]       cond;
  logic [3:0]       alu_flags;
  logic [1:0]       flag_w;
  logic             pcs;
  logic             reg_w;
  logic             mem_w;
  logic             stall;
  logic             flush;
  logic             cond_ex;
  logic [3:0]       flags_q;
  logic             pc_src_q;
  logic             reg_write_q;
  logic             mem_write_q;
  logic             valid_q;
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    output valid, cond, alu_flags, flag_w, pcs, reg_w, mem_w, stall, flush,
    input  cond_ex, flags_q, pc_src_q, reg_write_q, mem_write_q, valid_q, squash_cnt
  );

  modport slave (
    input  valid, cond, alu_flags, flag_w, pcs, reg_w, mem_w, stall, flush,
    output cond_ex, flags_q, pc_src_q, reg_write_q, mem_write_q, valid_q, squash_cnt
  );
endinterface

// File: rtl/cond_logic_unit.sv
// rtl/cond_logic_unit.sv - ZNCV flag register, ARM condition check and write-strobe gating
// Flags are {Z,N,C,V}; gated strobes are registered one cycle into the next stage.
module cond_logic_unit #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  cond_logic_unit_if.slave   bus
);
  logic [3:0]       flags_r;
  logic             pc_src_r;
  logic             reg_write_r;
  logic             mem_write_r;
  logic             valid_r;
  logic [CNT_W-1:0] squash_r;
  logic             z, n, c, v;
  logic             cond_true;
  logic             commit;
  logic             squash;

  assign {z, n, c, v} = flags_r;

  // Condition is judged against the committed flags, not this instruction's ALU result.
  always_comb begin
    cond_true = 1'b0;
    case (bus.cond)
      4'b0000: cond_true = z;
      4'b0001: cond_true = ~z;
      4'b0010: cond_true = c;
      4'b0011: cond_true = ~c;
      4'b0100: cond_true = n;
      4'b0101: cond_true = ~n;
      4'b0110: cond_true = v;
      4'b0111: cond_true = ~v;
      4'b1000: cond_true = c & ~z;
      4'b1001: cond_true = ~c | z;
      4'b1010: cond_true = (n == v);
      4'b1011: cond_true = (n != v);
      4'b1100: cond_true = ~z & (n == v);
      4'b1101: cond_true = z | (n != v);
      default: cond_true = 1'b1;
    endcase
  end

  assign commit = bus.valid & cond_true & ~bus.stall & ~bus.flush;
  assign squash = bus.valid & ~cond_true & ~bus.stall & ~bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r     <= 4'b0000;
      pc_src_r    <= 1'b0;
      reg_write_r <= 1'b0;
      mem_write_r <= 1'b0;
      valid_r     <= 1'b0;
      squash_r    <= '0;
    end else begin
      if (commit && bus.flag_w[1]) flags_r[3:2] <= bus.alu_flags[3:2];
      if (commit && bus.flag_w[0]) flags_r[1:0] <= bus.alu_flags[1:0];

      // Flush clears the stage even while stalled; a plain stall holds it.
      if (bus.flush) begin
        pc_src_r    <= 1'b0;
        reg_write_r <= 1'b0;
        mem_write_r <= 1'b0;
        valid_r     <= 1'b0;
      end else if (!bus.stall) begin
        pc_src_r    <= bus.pcs & commit;
        reg_write_r <= bus.reg_w & commit;
        mem_write_r <= bus.mem_w & commit;
        valid_r     <= bus.valid;
      end

      if (squash && (squash_r != {CNT_W{1'b1}})) squash_r <= squash_r + CNT_W'(1);
    end
  end

  assign bus.cond_ex     = cond_true;
  assign bus.flags_q     = flags_r;
  assign bus.pc_src_q    = pc_src_r;
  assign bus.reg_write_q = reg_write_r;
  assign bus.mem_write_q = mem_write_r;
  assign bus.valid_q     = valid_r;
  assign bus.squash_cnt  = squash_r;
endmodule

// File: tb/tb_cond_logic_unit.sv
// tb/tb_cond_logic_unit.sv - directed and randomized bench for cond_logic_unit
// A behavioural model of the flag/strobe pipeline tracks every clock edge.
module tb_cond_logic_unit;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int VEC_W   = 8 + CNT_W;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [3:0] m_flags;
  bit         m_pc, m_rw, m_mw, m_vq;
  int         m_cnt;

  cond_logic_unit_if #(.CNT_W(CNT_W)) ifc ();

  cond_logic_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Conditions come in true/inverted pairs; the odd code of each pair is the complement.
  function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
    bit z, n, cf, v, base;
    z = f[3]; n = f[2]; cf = f[1]; v = f[0];
    base = 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [VEC_W-1:0] exp_vec();
    return {m_flags, m_pc, m_rw, m_mw, m_vq, CNT_W'(m_cnt)};
  endfunction

  function automatic logic [VEC_W-1:0] dut_vec();
    return {ifc.flags_q, ifc.pc_src_q, ifc.reg_write_q, ifc.mem_write_q, ifc.valid_q, ifc.squash_cnt};
  endfunction

  task automatic drive(input bit vld, input logic [3:0] cnd, input logic [3:0] af,
                       input logic [1:0] fw, input bit p, input bit r, input bit m,
                       input bit st, input bit fl);
    ifc.valid = vld; ifc.cond = cnd; ifc.alu_flags = af; ifc.flag_w = fw;
    ifc.pcs = p; ifc.reg_w = r; ifc.mem_w = m; ifc.stall = st; ifc.flush = fl;
  endtask

  task automatic cycle();
    bit ce, go;
    @(posedge clk);
    ce = model_cond(ifc.cond, m_flags);
    if (reset) begin
      m_flags = 4'b0000; m_pc = 0; m_rw = 0; m_mw = 0; m_vq = 0; m_cnt = 0;
    end else begin
      go = ifc.valid && ce && !ifc.stall && !ifc.flush;
      if (ifc.flush) begin
        m_pc = 0; m_rw = 0; m_mw = 0; m_vq = 0;
      end else if (!ifc.stall) begin
        m_pc = ifc.pcs && go; m_rw = ifc.reg_w && go; m_mw = ifc.mem_w && go; m_vq = ifc.valid;
      end
      if (go && ifc.flag_w[1]) m_flags[3:2] = ifc.alu_flags[3:2];
      if (go && ifc.flag_w[0]) m_flags[1:0] = ifc.alu_flags[1:0];
      if (ifc.valid && !ce && !ifc.stall && !ifc.flush && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", dut_vec());
    end
    n_checks++;
    if (ifc.cond_ex !== 1'b0) begin
      n_fail++; $display("FAIL reset_eq_cond_ex got %b want 0", ifc.cond_ex);
    end
  endtask

  task automatic test_eq_ne();
    drive(1, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0, 0);
    cycle();
    n_checks++;
    if (ifc.flags_q !== 4'b1000) begin
      n_fail++; $display("FAIL al_load_flags got %b want 1000", ifc.flags_q);
    end
    drive(1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    n_checks++;
    if (ifc.cond_ex !== 1'b1) begin
      n_fail++; $display("FAIL eq_true got %b want 1", ifc.cond_ex);
    end
    cycle();
    drive(1, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    n_checks++;
    if (ifc.cond_ex !== 1'b0) begin
      n_fail++; $display("FAIL ne_false got %b want 0", ifc.cond_ex);
    end
    cycle();
    n_checks++;
    if (ifc.squash_cnt !== CNT_W'(1)) begin
      n_fail++; $display("FAIL ne_squash_cnt got %0d want 1", ifc.squash_cnt);
    end
  endtask

  task automatic test_ge_lt();
    drive(1, 4'b1110, 4'b0101, 2'b11, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
    n_checks++;
    if (ifc.cond_ex !== 1'b1) begin
      n_fail++; $display("FAIL ge_true got %b want 1", ifc.cond_ex);
    end
    cycle();
    n_checks++;
    if (ifc.reg_write_q !== 1'b1) begin
      n_fail++; $display("FAIL ge_reg_write got %b want 1", ifc.reg_write_q);
    end
    drive(1, 4'b1011, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
    cycle();
    n_checks++;
    if (ifc.reg_write_q !== 1'b0) begin
      n_fail++; $display("FAIL lt_reg_write got %b want 0", ifc.reg_write_q);
    end
  endtask

  task automatic test_partial_flags_and_stall();
    logic [VEC_W-1:0] held;
    drive(1, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 4'b1110, 4'b1111, 2'b01, 0, 0, 0, 0, 0);
    cycle();
    n_checks++;
    if (ifc.flags_q !== 4'b0011) begin
      n_fail++; $display("FAIL cv_only_load got %b want 0011", ifc.flags_q);
    end
    drive(1, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0, 0);
    cycle();
    held = {4'b0011, 4'b1111, CNT_W'(m_cnt)};
    drive(0, 4'b1110, 4'b1100, 2'b11, 0, 0, 0, 1, 0);
    cycle();
    drive(1, 4'b1110, 4'b1100, 2'b11, 0, 0, 0, 1, 0);
    cycle();
    n_checks++;
    if (dut_vec() !== held) begin
      n_fail++; $display("FAIL stall_hold got %h want %h", dut_vec(), held);
    end
  endtask

  task automatic test_flush();
    drive(1, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0, 0);
    cycle();
    drive(1, 4'b1110, 4'b1111, 2'b11, 0, 0, 1, 0, 1);
    cycle();
    n_checks++;
    if ({ifc.mem_write_q, ifc.valid_q, ifc.flags_q} !== {2'b00, 4'b0011}) begin
      n_fail++; $display("FAIL flush_kill got %b want 000011", {ifc.mem_write_q, ifc.valid_q, ifc.flags_q});
    end
    drive(1, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0, 0);
    cycle();
    drive(1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 1, 1);
    cycle();
    n_checks++;
    if ({ifc.pc_src_q, ifc.reg_write_q, ifc.mem_write_q, ifc.valid_q, ifc.flags_q} !== 8'b0000_0011) begin
      n_fail++; $display("FAIL flush_over_stall got %b want 00000011",
                         {ifc.pc_src_q, ifc.reg_write_q, ifc.mem_write_q, ifc.valid_q, ifc.flags_q});
    end
  endtask

  task automatic test_saturation();
    int want [5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
      cycle();
      n_checks++;
      if (ifc.squash_cnt !== CNT_W'(want[i])) begin
        n_fail++; $display("FAIL sat_step%0d got %0d want %0d", i, ifc.squash_cnt, want[i]);
      end
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++;
    if (ifc.squash_cnt !== '0) begin
      n_fail++; $display("FAIL sat_reset got %0d want 0", ifc.squash_cnt);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 4'b1110, 4'b1000, 2'b10, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 4'b0000, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
    n_checks++;
    if (ifc.cond_ex !== 1'b1) begin
      n_fail++; $display("FAIL b2b_sees_z got %b want 1", ifc.cond_ex);
    end
    cycle();
    drive(1, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    n_checks++;
    if ({ifc.flags_q, ifc.cond_ex} !== 5'b0000_1) begin
      n_fail++; $display("FAIL b2b_second got %b want 00001", {ifc.flags_q, ifc.cond_ex});
    end
    cycle();
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
    cycle();
    reset = 1'b1;
    drive(1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 1, 0);
    cycle();
    reset = 1'b0;
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL reset_mid_stall got %h want 0", dut_vec());
    end
  endtask

  task automatic test_random();
    bit want_ce;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 9) < 8, 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      want_ce = model_cond(ifc.cond, m_flags);
      n_checks++;
      if (ifc.cond_ex !== want_ce) begin
        n_fail++; $display("FAIL rand_cond_ex[%0d] cond=%b flags=%b got %b want %b",
                           i, ifc.cond, m_flags, ifc.cond_ex, want_ce);
      end
      cycle();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rand_state[%0d] got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    m_flags = 4'b0000; m_pc = 0; m_rw = 0; m_mw = 0; m_vq = 0; m_cnt = 0;
    test_reset();
    test_eq_ne();
    test_ge_lt();
    test_partial_flags_and_stall();
    test_flush();
    test_saturation();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
